// File: rtl/sc_mem_arbiter_if.sv
// Client-side and scratch-memory-side signal bundle for sc_mem_arbiter.
// Three clients are packed side by side; one memory port comes out.
interface sc_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128
);
    logic [2:0]          cl_req;
    logic [2:0]          cl_gnt;
    logic [3*ADDR_W-1:0] cl_rd_addr1;
    logic [3*ADDR_W-1:0] cl_rd_addr2;
    logic [3*ADDR_W-1:0] cl_wt_addr;
    logic [3*DATA_W-1:0] cl_wt_data;
    logic [2:0]          cl_wt_en;
    logic [ADDR_W-1:0]   sc_mem_rd_addr1;
    logic [ADDR_W-1:0]   sc_mem_rd_addr2;
    logic [ADDR_W-1:0]   sc_mem_wt_addr;
    logic [DATA_W-1:0]   sc_mem_wt_data;
    logic                sc_mem_wt_en;
    logic [2:0]          hold_err;

    modport master (
        output cl_req, cl_rd_addr1, cl_rd_addr2, cl_wt_addr, cl_wt_data, cl_wt_en,
        input  cl_gnt, hold_err, sc_mem_rd_addr1, sc_mem_rd_addr2, sc_mem_wt_addr,
               sc_mem_wt_data, sc_mem_wt_en
    );

    modport slave (
        input  cl_req, cl_rd_addr1, cl_rd_addr2, cl_wt_addr, cl_wt_data, cl_wt_en,
        output cl_gnt, hold_err, sc_mem_rd_addr1, sc_mem_rd_addr2, sc_mem_wt_addr,
               sc_mem_wt_data, sc_mem_wt_en
    );
endinterface

// File: rtl/sc_mem_arbiter.sv
// Round-robin arbiter giving one of three clients exclusive use of the scratch memory,
// with a bounded hold time and a forced dead cycle between owners.
module sc_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 128,
    parameter int MAX_HOLD = 256
) (
    input  logic            clk,
    input  logic            reset,
    sc_mem_arbiter_if.slave bus
);
    localparam int               CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_gnt, w_gnt_nxt;
    logic [1:0]        r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;
    logic [2:0]        r_hold_err, w_hold_err_nxt;
    logic [2:0]        w_pick;
    logic              w_any_req;
    logic              w_own_req;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_rd_addr1, w_rd_addr2, w_wt_addr;
    logic [DATA_W-1:0] w_wt_data;

    // First requester in the order ptr, ptr+1, ptr+2 (mod 3), one-hot.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] gnt;
        logic [2:0] idx;
        logic       found;
        gnt   = 3'b000;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end else begin
                idx = idx;
            end
            if (!found && req[idx[1:0]]) begin
                gnt[idx[1:0]] = 1'b1;
                found         = 1'b1;
            end else begin
                found = found;
            end
        end
        return gnt;
    endfunction

    function automatic logic [1:0] ptr_after(input logic [2:0] gnt);
        logic [1:0] ptr;
        case (gnt)
            3'b001:  ptr = 2'd1;
            3'b010:  ptr = 2'd2;
            3'b100:  ptr = 2'd0;
            default: ptr = 2'd0;
        endcase
        return ptr;
    endfunction

    assign w_pick    = rr_pick(bus.cl_req, r_rr_ptr);
    assign w_any_req = |bus.cl_req;
    assign w_own_req = |(bus.cl_req & r_gnt);
    assign w_timeout = (r_hold_cnt == HOLD_LAST);

    // State and registered-output flops; reset aborts any grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 3'b000;
            r_rr_ptr   <= 2'd0;
            r_hold_cnt <= {CNT_W{1'b0}};
            r_hold_err <= 3'b000;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_hold_err <= w_hold_err_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!w_own_req || w_timeout) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of grant, pointer, hold counter and sticky timeout flags.
    always_comb begin
        w_gnt_nxt      = r_gnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_hold_err_nxt = r_hold_err;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_gnt_nxt      = w_pick;
                    w_rr_ptr_nxt   = ptr_after(w_pick);
                    w_hold_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    w_gnt_nxt = 3'b000;
                end
            end
            ST_GRANT: begin
                if (!w_own_req) begin
                    w_gnt_nxt = 3'b000;
                end else if (w_timeout) begin
                    w_gnt_nxt      = 3'b000;
                    w_hold_err_nxt = r_hold_err | r_gnt;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1'b1);
                end
            end
            ST_RELEASE: w_gnt_nxt = 3'b000;
            default:    w_gnt_nxt = 3'b000;
        endcase
    end

    // One-hot AND-OR memory mux; a zero grant yields all-zero memory outputs.
    always_comb begin
        w_rd_addr1 = {ADDR_W{1'b0}};
        w_rd_addr2 = {ADDR_W{1'b0}};
        w_wt_addr  = {ADDR_W{1'b0}};
        w_wt_data  = {DATA_W{1'b0}};
        for (int i = 0; i < 3; i++) begin
            w_rd_addr1 = w_rd_addr1 | ({ADDR_W{r_gnt[i]}} & bus.cl_rd_addr1[i*ADDR_W +: ADDR_W]);
            w_rd_addr2 = w_rd_addr2 | ({ADDR_W{r_gnt[i]}} & bus.cl_rd_addr2[i*ADDR_W +: ADDR_W]);
            w_wt_addr  = w_wt_addr  | ({ADDR_W{r_gnt[i]}} & bus.cl_wt_addr[i*ADDR_W +: ADDR_W]);
            w_wt_data  = w_wt_data  | ({DATA_W{r_gnt[i]}} & bus.cl_wt_data[i*DATA_W +: DATA_W]);
        end
    end

    assign bus.cl_gnt          = r_gnt;
    assign bus.hold_err        = r_hold_err;
    assign bus.sc_mem_rd_addr1 = w_rd_addr1;
    assign bus.sc_mem_rd_addr2 = w_rd_addr2;
    assign bus.sc_mem_wt_addr  = w_wt_addr;
    assign bus.sc_mem_wt_data  = w_wt_data;
    assign bus.sc_mem_wt_en    = |(bus.cl_wt_en & r_gnt);
endmodule

// File: tb/tb_sc_mem_arbiter.sv
// Bench for sc_mem_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a tenure/cool-down model of the arbiter.
module tb_sc_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam int MH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: owner index (-1 = none), cycles the owner has been visibly granted,
    // a one-cycle cool-down after every release, round-robin start point, sticky flags.
    int         m_owner  = -1;
    int         m_tenure = 0;
    bit         m_cool   = 1'b0;
    int         m_ptr    = 0;
    logic [2:0] m_err    = 3'b000;
    int         m_c;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = -1; m_tenure = 0; m_cool = 1'b0; m_ptr = 0; m_err = 3'b000;
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 3; k++) begin
                m_c = (m_ptr + k) % 3;
                if (m_owner < 0 && bus.cl_req[m_c]) m_owner = m_c;
            end
            if (m_owner >= 0) begin
                m_tenure = 1;
                m_ptr    = (m_owner + 1) % 3;
            end
        end else if (!bus.cl_req[m_owner]) begin
            m_owner = -1; m_cool = 1'b1;
        end else if (m_tenure == MH) begin
            m_err[m_owner] = 1'b1;
            m_owner = -1; m_cool = 1'b1;
        end else begin
            m_tenure++;
        end
    end

    logic [2:0]   e_gnt;
    logic [AW-1:0] e_a1, e_a2, e_wa;
    logic [DW-1:0] e_wd;
    logic          e_we;

    always @(negedge clk) begin
        e_gnt = 3'b000; e_a1 = '0; e_a2 = '0; e_wa = '0; e_wd = '0; e_we = 1'b0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_a1 = bus.cl_rd_addr1[m_owner*AW +: AW];
            e_a2 = bus.cl_rd_addr2[m_owner*AW +: AW];
            e_wa = bus.cl_wt_addr[m_owner*AW +: AW];
            e_wd = bus.cl_wt_data[m_owner*DW +: DW];
            e_we = bus.cl_wt_en[m_owner];
        end
        check("gnt", bus.cl_gnt, e_gnt);
        check("hold_err", bus.hold_err, m_err);
        check("rd_addr1", bus.sc_mem_rd_addr1, e_a1);
        check("rd_addr2", bus.sc_mem_rd_addr2, e_a2);
        check("wt_addr", bus.sc_mem_wt_addr, e_wa);
        check("wt_data", bus.sc_mem_wt_data, e_wd);
        check("wt_en", bus.sc_mem_wt_en, e_we);
    end

    logic [2:0]    tr34 [18];
    logic [2:0]    tr37 [5];
    logic [DW-1:0] d2;
    int            run;
    bit            in_run;

    initial begin
        tr34 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
                 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
                 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
        tr37 = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b010};
        d2   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32C1;
        bus.cl_req = 3'b000; bus.cl_wt_en = 3'b000;
        bus.cl_rd_addr1 = '0; bus.cl_rd_addr2 = '0; bus.cl_wt_addr = '0; bus.cl_wt_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_gnt", bus.cl_gnt, 3'b000);
        check("reset_err", bus.hold_err, 3'b000);
        check("reset_we", bus.sc_mem_wt_en, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        // All three request together; each keeps its grant for four cycles.
        @(posedge clk); #1 bus.cl_req = 3'b111;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            if (k == 3)  bus.cl_req[0] = 1'b0;
            if (k == 9)  bus.cl_req[1] = 1'b0;
            if (k == 15) bus.cl_req[2] = 1'b0;
            @(negedge clk);
            check("rr_trace", bus.cl_gnt, tr34[k]);
        end

        // Client 2 owns the memory while everyone drives a write.
        @(posedge clk); #1;
        bus.cl_req = 3'b100; bus.cl_wt_en = 3'b111;
        bus.cl_wt_addr = {16'h0030, 16'h0020, 16'h0010};
        bus.cl_wt_data = {d2, {16{8'hB1}}, {16{8'hA0}}};
        @(posedge clk); @(negedge clk);
        check("c2_gnt", bus.cl_gnt, 3'b100);
        check("c2_we", bus.sc_mem_wt_en, 1'b1);
        check("c2_waddr", bus.sc_mem_wt_addr, 16'h0030);
        check("c2_wdata", bus.sc_mem_wt_data, d2);
        @(posedge clk); #1 bus.cl_req = 3'b000; bus.cl_wt_en = 3'b000;
        repeat (3) @(posedge clk);

        // Client 1 alone holds its request for 20 cycles: timeout after 8.
        #1 bus.cl_req = 3'b010;
        run = 0; in_run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (in_run && bus.cl_gnt[1]) run++; else in_run = 1'b0;
            if (k == 10) check("regrant", bus.cl_gnt, 3'b010);
        end
        check("hold_len", 32'(run), 32'd8);
        check("hold_err1", bus.hold_err, 3'b010);
        @(posedge clk); #1 bus.cl_req = 3'b000;
        repeat (4) @(posedge clk);

        // Owner hands off to another client in the same cycle, then reset mid-write.
        #1 bus.cl_req = 3'b001;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin bus.cl_req = 3'b010; bus.cl_wt_en = 3'b010; end
            @(negedge clk);
            check("handoff", bus.cl_gnt, tr37[k]);
        end
        check("pre_rst_we", bus.sc_mem_wt_en, 1'b1);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("rst_gnt", bus.cl_gnt, 3'b000);
        check("rst_we", bus.sc_mem_wt_en, 1'b0);
        check("rst_err", bus.hold_err, 3'b000);
        @(posedge clk); #1 reset = 1'b0; bus.cl_req = 3'b110; bus.cl_wt_en = 3'b000;
        @(posedge clk); @(negedge clk);
        check("post_rst", bus.cl_gnt, 3'b010);

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) reset = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 4) == 0) bus.cl_req[i] = ~bus.cl_req[i];
                for (int w = 0; w < 4; w++) bus.cl_wt_data[i*DW + w*32 +: 32] = $urandom;
            end
            bus.cl_wt_en    = 3'($urandom);
            bus.cl_rd_addr1 = 48'({$urandom, $urandom});
            bus.cl_rd_addr2 = 48'({$urandom, $urandom});
            bus.cl_wt_addr  = 48'({$urandom, $urandom});
        end
        @(posedge clk); #1 bus.cl_req = 3'b000; reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
